uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter among up to NUM_REQ byte sources using round-robin arbitration with optional message locking. It sits between client logic and the transmitter, driving the transmitter's data_in and wr_en and tracking its Tx_busy. It serialises byte issue so that a new write is never presented while a frame is in flight. It also flags a transmitter that fails to start.

---
 rtl/uart_ctrl_pkg.sv | 17 +
 rtl/rr_pick.sv | 41 ++++
 rtl/uart_tx_arbiter.sv | 139 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared constants for the UART control blocks: FSM state encoding and default sizing.
package uart_ctrl_pkg;

    localparam int DATA_W_DEF        = 8;
    localparam int START_TIMEOUT_DEF = 16;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t ARM  = 2'd1;
    localparam state_t SEND = 2'd2;

    // Index of the requester after id, wrapping at n.
    function automatic int wrap_inc(input int id, input int n);
        return (id + 1 >= n) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker with an optional lock onto a single requester.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    input  logic          i_lock_en,
    input  logic [IW-1:0] i_lock_id,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_gnt_id
);

    logic          w_found;
    logic [IW-1:0] w_idx;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        o_gnt    = '0;
        o_gnt_id = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        if (i_lock_en) begin
            if (i_req[i_lock_id]) begin
                o_gnt[i_lock_id] = 1'b1;
                o_gnt_id         = i_lock_id;
            end
        end else begin
            // First valid requester at or after the pointer wins.
            for (int i = 0; i < N; i++) begin
                w_idx = IW'((int'(i_ptr) + i) % N);
                if (!w_found && i_req[w_idx]) begin
                    w_found      = 1'b1;
                    o_gnt[w_idx] = 1'b1;
                    o_gnt_id     = w_idx;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources,
// with message locking and a sticky start-timeout flag.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int  NUM_REQ       = 4,
    parameter int  DATA_W        = DATA_W_DEF,
    parameter int  START_TIMEOUT = START_TIMEOUT_DEF,
    localparam int IW            = $clog2(NUM_REQ),
    localparam int CW            = $clog2(START_TIMEOUT + 1)
) (
    input  logic                      clk_50m,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_wr_en,
    input  logic                      tx_busy,
    output logic [IW-1:0]             grant_id,
    output logic                      locked,
    output logic                      err_timeout,
    input  logic                      err_clr
);

    state_t            r_state;
    state_t            w_next_state;
    logic [DATA_W-1:0] r_tx_data;
    logic              r_tx_wr_en;
    logic [IW-1:0]     r_grant_id;
    logic [IW-1:0]     r_lock_id;
    logic [IW-1:0]     r_rr_ptr;
    logic              r_locked;
    logic              r_err;
    logic [CW-1:0]     r_cnt;

    logic [NUM_REQ-1:0] w_gnt;
    logic [NUM_REQ-1:0] w_ready;
    logic [IW-1:0]      w_gnt_id;
    logic [DATA_W-1:0]  w_win_data;
    logic               w_win_last;
    logic               w_accept;
    logic               w_timeout;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr_pick (
        .i_req     (req_valid),
        .i_ptr     (r_rr_ptr),
        .i_lock_en (r_locked),
        .i_lock_id (r_lock_id),
        .o_gnt     (w_gnt),
        .o_gnt_id  (w_gnt_id)
    );

    always_comb begin
        w_win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) w_win_data = req_data[i*DATA_W +: DATA_W];
        end
    end

    assign w_win_last = |(req_last & w_gnt);
    assign w_accept   = |(req_valid & w_ready);
    assign w_timeout  = (r_state == ARM) && !tx_busy
                        && (r_cnt == CW'(START_TIMEOUT - 1));

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = ARM;
            ARM: begin
                if (tx_busy)        w_next_state = SEND;
                else if (w_timeout) w_next_state = IDLE;
            end
            SEND:    if (!tx_busy) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Ready is gated by rst_n so it drops at once when reset asserts.
    always_comb begin
        w_ready = '0;
        if (rst_n && (r_state == IDLE) && !tx_busy) w_ready = w_gnt;
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_data  <= '0;
            r_tx_wr_en <= 1'b0;
            r_grant_id <= '0;
            r_lock_id  <= '0;
            r_rr_ptr   <= '0;
            r_locked   <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_tx_wr_en <= w_accept;
            if (w_accept) begin
                r_tx_data  <= w_win_data;
                r_grant_id <= w_gnt_id;
                r_cnt      <= '0;
                if (w_win_last) begin
                    r_locked <= 1'b0;
                    r_rr_ptr <= IW'(wrap_inc(int'(w_gnt_id), NUM_REQ));
                end else begin
                    r_locked  <= 1'b1;
                    r_lock_id <= w_gnt_id;
                end
            end else if ((r_state == ARM) && !tx_busy) begin
                if (w_timeout) begin
                    r_locked <= 1'b0;
                    r_rr_ptr <= IW'(wrap_inc(int'(r_grant_id), NUM_REQ));
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
            // A timeout in the same cycle as err_clr keeps the flag set.
            if (w_timeout)    r_err <= 1'b1;
            else if (err_clr) r_err <= 1'b0;
        end
    end

    assign req_ready   = w_ready;
    assign tx_data     = r_tx_data;
    assign tx_wr_en    = r_tx_wr_en;
    assign grant_id    = r_grant_id;
    assign locked      = r_locked;
    assign err_timeout = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a simple transmitter model
// (busy rises one cycle after wr_en and lasts 20 cycles, or never when tx_dead is set).
module tb_uart_tx_arbiter;

    logic        clk_50m = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_wr_en;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        locked;
    logic        err_timeout;
    logic        err_clr;
    logic        tx_dead;

    int n_vec = 0;
    int n_err = 0;
    int viol  = 0;
    int busy_cnt;
    logic prev_wr;

    always #10 clk_50m = ~clk_50m;

    uart_tx_arbiter #(
        .NUM_REQ       (4),
        .DATA_W        (8),
        .START_TIMEOUT (16)
    ) dut (
        .clk_50m     (clk_50m),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_wr_en    (tx_wr_en),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .locked      (locked),
        .err_timeout (err_timeout),
        .err_clr     (err_clr)
    );

    always @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n)                   busy_cnt <= 0;
        else if (tx_wr_en && !tx_dead) busy_cnt <= 20;
        else if (busy_cnt != 0)        busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    // Protocol watch: no write while busy, single-cycle pulses, ready one-hot and quiet while busy.
    always @(negedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            prev_wr <= 1'b0;
        end else begin
            if ((tx_wr_en && (tx_busy || prev_wr)) || ((req_ready != 4'b0) && tx_busy)
                || ($countones(req_ready) > 1))
                viol <= viol + 1;
            prev_wr <= tx_wr_en;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_50m);
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
        req_valid[i]       = v;
        req_data[i*8 +: 8] = d;
        req_last[i]        = l;
    endtask

    task automatic wait_wr(input string tag, input int budget);
        int n = 0;
        do begin
            @(negedge clk_50m);
            n++;
        end while (!tx_wr_en && n < budget);
        check({tag, "_wr_seen"}, 32'(tx_wr_en), 32'd1);
    endtask

    task automatic wait_quiet(input string tag);
        int quiet = 0;
        int n     = 0;
        while (quiet < 3 && n < 200) begin
            @(negedge clk_50m);
            n++;
            quiet = tx_busy ? 0 : quiet + 1;
        end
        check({tag, "_quiet"}, 32'(quiet >= 3), 32'd1);
    endtask

    initial begin
        logic [1:0] exp_id;

        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_data  = '0;
        req_last  = '0;
        err_clr   = 1'b0;
        tx_dead   = 1'b0;

        // Reset state, with every requester valid to show ready held low.
        step(2);
        check("rst_wr_en",  32'(tx_wr_en),    32'd0);
        check("rst_data",   32'(tx_data),     32'd0);
        check("rst_grant",  32'(grant_id),    32'd0);
        check("rst_locked", 32'(locked),      32'd0);
        check("rst_err",    32'(err_timeout), 32'd0);
        check("rst_ready",  32'(req_ready),   32'd0);
        req_valid = 4'h0;
        rst_n     = 1'b1;
        step(1);

        // Single byte from requester 2.
        set_req(2, 1'b1, 8'h55, 1'b1);
        #1 check("single_ready", 32'(req_ready), 32'b0100);
        wait_wr("single", 5);
        check("single_data",     32'(tx_data),   32'h55);
        check("single_grant",    32'(grant_id),  32'd2);
        check("single_ready_off", 32'(req_ready), 32'd0);
        set_req(2, 1'b0, 8'h55, 1'b1);
        step(1);
        check("single_pulse_end", 32'(tx_wr_en), 32'd0);
        wait_quiet("single");
        check("single_hold", 32'(tx_data), 32'h55);

        // Fairness: rr_ptr is 3 now, so order is 3,0,1,2,3,0.
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'hA0 + 8'(i), 1'b1);
        #1 check("rr_first_ready", 32'(req_ready), 32'b1000);
        for (int k = 0; k < 6; k++) begin
            exp_id = 2'(3 + k);
            wait_wr($sformatf("rr%0d", k), 40);
            check($sformatf("rr%0d_grant", k), 32'(grant_id), 32'(exp_id));
            check($sformatf("rr%0d_data", k),  32'(tx_data),  32'(8'hA0 + 8'(exp_id)));
        end
        req_valid = 4'h0;
        wait_quiet("rr");

        // Lock: rr_ptr is 1; requester 1 locks, requester 0 waits throughout.
        set_req(1, 1'b1, 8'hC9, 1'b0);
        set_req(0, 1'b1, 8'h11, 1'b1);
        #1 check("lock_ready1", 32'(req_ready), 32'b0010);
        wait_wr("lock_b0", 5);
        check("lock_b0_grant",  32'(grant_id), 32'd1);
        check("lock_b0_data",   32'(tx_data),  32'hC9);
        check("lock_b0_locked", 32'(locked),   32'd1);
        set_req(1, 1'b0, 8'hAE, 1'b1);
        wait_quiet("lock_hold");
        check("lock_hold_ready",  32'(req_ready), 32'd0);
        check("lock_hold_locked", 32'(locked),    32'd1);
        set_req(1, 1'b1, 8'hAE, 1'b1);
        #1 check("lock_ready2", 32'(req_ready), 32'b0010);
        wait_wr("lock_b1", 5);
        check("lock_b1_grant",  32'(grant_id), 32'd1);
        check("lock_b1_data",   32'(tx_data),  32'hAE);
        check("lock_b1_locked", 32'(locked),   32'd0);
        set_req(1, 1'b0, 8'hAE, 1'b1);
        wait_wr("lock_next", 40);
        check("lock_next_grant", 32'(grant_id), 32'd0);
        check("lock_next_data",  32'(tx_data),  32'h11);
        set_req(0, 1'b0, 8'h11, 1'b1);
        wait_quiet("lock");

        // Start timeout with a transmitter that never goes busy.
        tx_dead = 1'b1;
        set_req(2, 1'b1, 8'h3C, 1'b0);
        wait_wr("to", 5);
        check("to_grant",  32'(grant_id), 32'd2);
        check("to_locked", 32'(locked),   32'd1);
        set_req(2, 1'b0, 8'h3C, 1'b0);
        step(15);
        check("to_err_early", 32'(err_timeout), 32'd0);
        step(1);
        check("to_err_set",   32'(err_timeout), 32'd1);
        check("to_unlocked",  32'(locked),      32'd0);
        set_req(0, 1'b1, 8'h5A, 1'b1);
        #1 check("to_idle_ready", 32'(req_ready), 32'b0001);
        step(1);
        check("to2_wr",    32'(tx_wr_en), 32'd1);
        check("to2_grant", 32'(grant_id), 32'd0);
        set_req(0, 1'b0, 8'h5A, 1'b1);
        err_clr = 1'b1;
        step(1);
        check("clr_err", 32'(err_timeout), 32'd0);
        err_clr = 1'b0;
        step(14);
        check("to2_err_early", 32'(err_timeout), 32'd0);
        err_clr = 1'b1;
        step(1);
        check("set_wins", 32'(err_timeout), 32'd1);
        err_clr = 1'b0;
        tx_dead = 1'b0;
        err_clr = 1'b1;
        step(1);
        check("clr_err2", 32'(err_timeout), 32'd0);
        err_clr = 1'b0;

        // Reset while a locked message is in SEND; rr_ptr is 1 so requester 3 wins alone.
        set_req(3, 1'b1, 8'h77, 1'b0);
        wait_wr("mid", 5);
        check("mid_grant", 32'(grant_id), 32'd3);
        set_req(3, 1'b0, 8'h77, 1'b0);
        step(2);
        check("mid_locked", 32'(locked), 32'd1);
        set_req(0, 1'b1, 8'h99, 1'b1);
        set_req(3, 1'b1, 8'h78, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_wr",     32'(tx_wr_en),    32'd0);
        check("mid_rst_data",   32'(tx_data),     32'd0);
        check("mid_rst_grant",  32'(grant_id),    32'd0);
        check("mid_rst_locked", 32'(locked),      32'd0);
        check("mid_rst_err",    32'(err_timeout), 32'd0);
        check("mid_rst_ready",  32'(req_ready),   32'd0);
        step(2);
        rst_n = 1'b1;
        #1 check("post_rst_ready", 32'(req_ready), 32'b0001);
        wait_wr("post_rst", 5);
        check("post_rst_grant", 32'(grant_id), 32'd0);
        check("post_rst_data",  32'(tx_data),  32'h99);
        req_valid = 4'h0;
        wait_quiet("end");

        check("protocol_violations", 32'(viol), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
